// File: rtl/vend_pkg.sv
// Shared constants for the vending controller: state codes, coin values,
// credit width and the coin-value helper.
package vend_pkg;

    localparam int unsigned CREDIT_W = 4;
    localparam int unsigned ARITH_W  = CREDIT_W + 1;

    localparam logic [2:0] S_IDLE   = 3'b000;
    localparam logic [2:0] S_CREDIT = 3'b001;
    localparam logic [2:0] S_VEND   = 3'b011;
    localparam logic [2:0] S_CHANGE = 3'b010;
    localparam logic [2:0] S_GAP    = 3'b110;
    localparam logic [2:0] S_FAULT  = 3'b101;

    localparam logic [ARITH_W-1:0] NICKEL_VAL = 5'd1;
    localparam logic [ARITH_W-1:0] DIME_VAL   = 5'd2;

    // Value of the coins presented in one cycle; both together are worth 3.
    function automatic logic [ARITH_W-1:0] coin_value(input logic nickel, input logic dime);
        coin_value = (nickel ? NICKEL_VAL : '0) + (dime ? DIME_VAL : '0);
    endfunction

endpackage

// File: rtl/vend_credit.sv
// Credit register with add-if-it-fits and guarded subtract.
// The controller decides which operation applies in a given cycle.
module vend_credit
    import vend_pkg::*;
#(
    parameter int unsigned PRICE      = 4,
    parameter int unsigned MAX_CREDIT = 15
) (
    input  logic                CLK,
    input  logic                Reset,
    input  logic                add_en,
    input  logic [ARITH_W-1:0]  add_val,
    input  logic                dec_price,
    input  logic                dec_one,
    output logic [CREDIT_W-1:0] credit,
    output logic                add_fits
);

    localparam logic [ARITH_W-1:0] PRICE_W = ARITH_W'(PRICE);
    localparam logic [ARITH_W-1:0] MAX_W   = ARITH_W'(MAX_CREDIT);
    localparam logic [ARITH_W-1:0] ONE_W   = ARITH_W'(1);

    logic [ARITH_W-1:0] credit_w;
    logic [ARITH_W-1:0] sum;

    // Widened sum so an overflowing coin is detected instead of wrapping.
    always_comb begin
        credit_w = {1'b0, credit};
        sum      = credit_w + add_val;
        add_fits = (sum <= MAX_W);
    end

    // Credit update; subtraction only happens when it cannot underflow.
    always_ff @(posedge CLK) begin
        if (!Reset) begin
            credit <= '0;
        end else if (add_en && add_fits) begin
            credit <= CREDIT_W'(sum);
        end else if (dec_price && (credit_w >= PRICE_W)) begin
            credit <= CREDIT_W'(credit_w - PRICE_W);
        end else if (dec_one && (credit_w >= ONE_W)) begin
            credit <= CREDIT_W'(credit_w - ONE_W);
        end
    end

endmodule

// File: rtl/vend_ctrl.sv
// Vending machine controller: coin acceptance, vend handshake with
// timeout, and a one-nickel-every-two-cycles refund loop.
module vend_ctrl
    import vend_pkg::*;
#(
    parameter int unsigned PRICE        = 4,
    parameter int unsigned MAX_CREDIT   = 15,
    parameter int unsigned VEND_TIMEOUT = 255
) (
    input  logic                CLK,
    input  logic                Reset,
    input  logic                Nickel,
    input  logic                Dime,
    input  logic                Select,
    input  logic                Cancel,
    input  logic                VendDone,
    output logic                Dispense,
    output logic                ReturnNickel,
    output logic                CoinReject,
    output logic [CREDIT_W-1:0] Credit,
    output logic                Fault,
    output logic [2:0]          State
);

    localparam int unsigned TO_W = (VEND_TIMEOUT > 2) ? $clog2(VEND_TIMEOUT) : 1;
    localparam logic [TO_W-1:0]    TO_LAST = TO_W'(VEND_TIMEOUT - 1);
    localparam logic [ARITH_W-1:0] PRICE_W = ARITH_W'(PRICE);

    logic [2:0]         next_state;
    logic [TO_W-1:0]    to_cnt;
    logic [ARITH_W-1:0] add_val;
    logic [ARITH_W-1:0] credit_w;
    logic               coin;
    logic               add_en;
    logic               add_fits;
    logic               dec_price;
    logic               dec_one;

    vend_credit #(
        .PRICE      (PRICE),
        .MAX_CREDIT (MAX_CREDIT)
    ) u_credit (
        .CLK       (CLK),
        .Reset     (Reset),
        .add_en    (add_en),
        .add_val   (add_val),
        .dec_price (dec_price),
        .dec_one   (dec_one),
        .credit    (Credit),
        .add_fits  (add_fits)
    );

    // Next-state and credit-operation selection.
    // Cancel outranks Select, and either one taking effect refuses a same-cycle coin.
    always_comb begin
        next_state = State;
        add_en     = 1'b0;
        dec_price  = 1'b0;
        dec_one    = 1'b0;
        add_val    = coin_value(Nickel, Dime);
        coin       = Nickel | Dime;
        credit_w   = {1'b0, Credit};
        case (State)
            S_IDLE, S_CREDIT: begin
                if (Cancel) begin
                    if (credit_w != '0) next_state = S_CHANGE;
                end else if (Select && (State == S_CREDIT) && (credit_w >= PRICE_W)) begin
                    next_state = S_VEND;
                end else if (coin && add_fits) begin
                    add_en     = 1'b1;
                    next_state = S_CREDIT;
                end
            end
            S_VEND: begin
                if (VendDone) begin
                    dec_price  = 1'b1;
                    next_state = (credit_w > PRICE_W) ? S_CHANGE : S_IDLE;
                end else if (to_cnt == TO_LAST) begin
                    next_state = S_FAULT;
                end
            end
            S_CHANGE: begin
                dec_one    = 1'b1;
                next_state = S_GAP;
            end
            S_GAP:   next_state = (credit_w != '0) ? S_CHANGE : S_IDLE;
            S_FAULT: next_state = S_FAULT;
            default: next_state = S_IDLE;
        endcase
    end

    // State and registered outputs, decoded from the state being entered.
    always_ff @(posedge CLK) begin
        if (!Reset) begin
            State        <= S_IDLE;
            Dispense     <= 1'b0;
            ReturnNickel <= 1'b0;
            CoinReject   <= 1'b0;
            Fault        <= 1'b0;
        end else begin
            State        <= next_state;
            Dispense     <= (next_state == S_VEND);
            ReturnNickel <= (next_state == S_CHANGE);
            CoinReject   <= coin && !add_en;
            Fault        <= (next_state == S_FAULT);
        end
    end

    // Cycles spent in VEND since entry; cleared whenever VEND is not held.
    always_ff @(posedge CLK) begin
        if (!Reset) begin
            to_cnt <= '0;
        end else if ((State == S_VEND) && (next_state == S_VEND)) begin
            to_cnt <= to_cnt + 1'b1;
        end else begin
            to_cnt <= '0;
        end
    end

endmodule

// File: tb/tb_vend_ctrl.sv
// Self-checking bench for vend_ctrl: directed scenarios plus random
// stimulus, compared every cycle against a behavioural model.
module tb_vend_ctrl;

    localparam int PRICE   = 4;
    localparam int MAXC    = 15;
    localparam int TIMEOUT = 255;

    logic       CLK = 1'b0;
    logic       Reset = 1'b0;
    logic       Nickel = 1'b0, Dime = 1'b0, Select = 1'b0, Cancel = 1'b0, VendDone = 1'b0;
    logic       Dispense, ReturnNickel, CoinReject, Fault;
    logic [3:0] Credit;
    logic [2:0] State;

    vend_ctrl #(
        .PRICE        (PRICE),
        .MAX_CREDIT   (MAXC),
        .VEND_TIMEOUT (TIMEOUT)
    ) dut (
        .CLK          (CLK),
        .Reset        (Reset),
        .Nickel       (Nickel),
        .Dime         (Dime),
        .Select       (Select),
        .Cancel       (Cancel),
        .VendDone     (VendDone),
        .Dispense     (Dispense),
        .ReturnNickel (ReturnNickel),
        .CoinReject   (CoinReject),
        .Credit       (Credit),
        .Fault        (Fault),
        .State        (State)
    );

    always #5 CLK = ~CLK;

    typedef enum {M_IDLE, M_CREDIT, M_VEND, M_CHANGE, M_GAP, M_FAULT} mode_t;

    mode_t m_mode = M_IDLE;
    int    m_credit = 0;
    int    m_vend_cycles = 0;
    bit    m_reject = 1'b0;
    int    n_checks = 0;
    int    n_err = 0;
    int    step_no = 0;

    function automatic logic [2:0] code_of(input mode_t m);
        case (m)
            M_IDLE:   code_of = 3'b000;
            M_CREDIT: code_of = 3'b001;
            M_VEND:   code_of = 3'b011;
            M_CHANGE: code_of = 3'b010;
            M_GAP:    code_of = 3'b110;
            default:  code_of = 3'b101;
        endcase
    endfunction

    // Behavioural model: what the machine should look like after this edge.
    task automatic model(input bit n, input bit d, input bit s, input bit c, input bit vd, input bit rst);
        int  val;
        bit  taken;
        val   = int'(n) + 2 * int'(d);
        taken = 1'b0;
        if (!rst) begin
            m_mode = M_IDLE; m_credit = 0; m_vend_cycles = 0; m_reject = 1'b0;
            return;
        end
        case (m_mode)
            M_IDLE, M_CREDIT: begin
                if (c) begin
                    if (m_credit > 0) m_mode = M_CHANGE;
                end else if (s && m_mode == M_CREDIT && m_credit >= PRICE) begin
                    m_mode = M_VEND; m_vend_cycles = 0;
                end else if (val > 0 && m_credit + val <= MAXC) begin
                    m_credit += val; taken = 1'b1; m_mode = M_CREDIT;
                end
            end
            M_VEND: begin
                m_vend_cycles++;
                if (vd) begin
                    m_credit -= PRICE;
                    m_mode = (m_credit > 0) ? M_CHANGE : M_IDLE;
                end else if (m_vend_cycles >= TIMEOUT) begin
                    m_mode = M_FAULT;
                end
            end
            M_CHANGE: begin m_credit -= 1; m_mode = M_GAP; end
            M_GAP:    m_mode = (m_credit > 0) ? M_CHANGE : M_IDLE;
            default:  ;
        endcase
        m_reject = (val > 0) && !taken;
    endtask

    // Apply one cycle of inputs, advance the model, and check every output.
    task automatic step(input bit n, input bit d, input bit s, input bit c, input bit vd, input bit rst);
        logic [10:0] act, exp;
        Nickel = n; Dime = d; Select = s; Cancel = c; VendDone = vd; Reset = rst;
        model(n, d, s, c, vd, rst);
        @(posedge CLK);
        #1;
        step_no++;
        act = {State, Credit, Dispense, ReturnNickel, CoinReject, Fault};
        exp = {code_of(m_mode), 4'(m_credit), m_mode == M_VEND, m_mode == M_CHANGE,
               m_reject, m_mode == M_FAULT};
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL cycle%0d {State,Credit,Disp,RN,Rej,Fault}: got %b_%0d_%b%b%b%b want %b_%0d_%b%b%b%b",
                     step_no, act[10:8], act[7:4], act[3], act[2], act[1], act[0],
                     exp[10:8], exp[7:4], exp[3], exp[2], exp[1], exp[0]);
        end
    endtask

    task automatic lit(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) step(0, 0, 0, 0, 0, 1);
    endtask

    task automatic do_reset();
        step(0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        int rn_cnt;
        int first_rn, second_rn;

        // Reset state
        do_reset();
        lit("reset_state", int'(State), 0);
        lit("reset_credit", int'(Credit), 0);

        // Basic purchase, exact price, no change
        step(1, 0, 0, 0, 0, 1);  lit("n_credit1", int'(Credit), 1);
        step(0, 1, 0, 0, 0, 1);  lit("d_credit3", int'(Credit), 3);
        step(0, 0, 1, 0, 0, 1);  lit("sel_short_disp", int'(Dispense), 0);
        step(1, 0, 0, 0, 0, 1);  lit("credit4", int'(Credit), 4);
        step(0, 0, 1, 0, 0, 1);  lit("sel_disp", int'(Dispense), 1);
        lit("sel_state_vend", int'(State), 3);
        idle(1);
        step(0, 0, 0, 0, 1, 1);
        lit("vend_credit0", int'(Credit), 0);
        lit("vend_idle", int'(State), 0);
        lit("vend_no_rn", int'(ReturnNickel), 0);
        idle(2);

        // Overpay by two nickels: two refunds two cycles apart
        do_reset();
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0, 1);
        step(0, 0, 1, 0, 0, 1);
        idle(4);
        step(0, 0, 0, 0, 1, 1);
        lit("change_credit2", int'(Credit), 2);
        rn_cnt = 0; first_rn = -1; second_rn = -1;
        for (int i = 0; i < 8; i++) begin
            if (ReturnNickel) begin
                if (rn_cnt == 0) first_rn = i; else second_rn = i;
                rn_cnt++;
            end
            idle(1);
        end
        lit("change_pulses", rn_cnt, 2);
        lit("change_spacing", second_rn - first_rn, 2);
        lit("change_end_idle", int'(State), 0);

        // Credit ceiling
        do_reset();
        for (int i = 0; i < 7; i++) step(0, 1, 0, 0, 0, 1);
        step(0, 1, 0, 0, 0, 1);
        lit("ceil_reject", int'(CoinReject), 1);
        lit("ceil_credit14", int'(Credit), 14);
        step(1, 0, 0, 0, 0, 1);
        lit("ceil_credit15", int'(Credit), 15);
        do_reset();
        for (int i = 0; i < 6; i++) step(0, 1, 0, 0, 0, 1);
        step(1, 0, 0, 0, 0, 1);
        step(1, 1, 0, 0, 0, 1);
        lit("nd_reject", int'(CoinReject), 1);
        lit("nd_credit13", int'(Credit), 13);

        // Dispenser timeout
        do_reset();
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0, 1);
        step(0, 0, 1, 0, 0, 1);
        idle(TIMEOUT - 1);
        lit("to_still_vend", int'(State), 3);
        idle(1);
        lit("to_state", int'(State), 5);
        lit("to_fault", int'(Fault), 1);
        lit("to_credit6", int'(Credit), 6);
        lit("to_disp", int'(Dispense), 0);
        step(1, 0, 1, 1, 1, 1);
        lit("fault_hold", int'(State), 5);
        do_reset();
        lit("fault_clear", int'({State, Credit, Dispense, ReturnNickel, CoinReject, Fault}), 0);

        // Select and Cancel together: full refund, no dispense
        step(0, 1, 0, 0, 0, 1);
        step(0, 1, 0, 0, 0, 1);
        step(1, 0, 0, 0, 0, 1);
        step(0, 0, 1, 1, 0, 1);
        rn_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            if (ReturnNickel) rn_cnt++;
            lit("cancel_no_disp", int'(Dispense), 0);
            idle(1);
        end
        lit("cancel_pulses5", rn_cnt, 5);

        // Reset aborts refund
        do_reset();
        step(0, 1, 0, 0, 0, 1);
        step(0, 1, 0, 0, 0, 1);
        step(0, 0, 0, 1, 0, 1);
        rn_cnt = int'(ReturnNickel);
        for (int i = 0; i < 6 && rn_cnt < 2; i++) begin
            idle(1);
            if (ReturnNickel) rn_cnt++;
        end
        lit("abort_two_seen", rn_cnt, 2);
        do_reset();
        rn_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            idle(1);
            if (ReturnNickel) rn_cnt++;
        end
        lit("abort_no_more", rn_cnt, 0);
        lit("abort_credit0", int'(Credit), 0);
        lit("abort_idle", int'(State), 0);

        // Random traffic
        for (int i = 0; i < 4000; i++) begin
            step($urandom_range(99) < 30, $urandom_range(99) < 25, $urandom_range(99) < 20,
                 $urandom_range(99) < 4, $urandom_range(99) < 15, $urandom_range(999) >= 5);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/vend_ctrl.md
VEND_CTRL -- requirements
Module: vend_ctrl

Interface
REQ-001 Parameter PRICE, default 4, item price in nickels (20 cents).
REQ-002 Parameter MAX_CREDIT, default 15, credit ceiling in nickels.
REQ-003 Parameter VEND_TIMEOUT, default 255, maximum cycles spent waiting for VendDone.
REQ-004 CLK  input  1  clock; all state changes on the rising edge.
REQ-005 Reset  input  1  synchronous, active-low reset.
REQ-006 Nickel  input  1  one-cycle pulse; coin worth 1 credit unit.
REQ-007 Dime  input  1  one-cycle pulse; coin worth 2 credit units.
REQ-008 Select  input  1  one-cycle pulse; purchase request.
REQ-009 Cancel  input  1  one-cycle pulse; refund request.
REQ-010 VendDone  input  1  dispenser acknowledge; item has dropped.
REQ-011 Dispense  output  1  registered; dispenser request, held until acknowledged.
REQ-012 ReturnNickel  output  1  registered; one-cycle pulse, each pulse ejects one nickel.
REQ-013 CoinReject  output  1  registered; one-cycle pulse, the coin in the previous cycle was refused.
REQ-014 Credit  output  4  registered; current credit in nickels.
REQ-015 Fault  output  1  registered; dispenser timeout latched.
REQ-016 State  output  3  registered; current state code.

Function
REQ-017 States and codes: IDLE=000, CREDIT=001, VEND=011, CHANGE=010, GAP=110, FAULT=101.
REQ-018 IDLE/CREDIT coin acceptance:
- Coin value: Nickel + 2*Dime; Nickel and Dime together add 3.
- If Credit + value <= MAX_CREDIT: the value is added on the next edge.
- Otherwise: Credit is unchanged and CoinReject pulses on the next cycle.
REQ-019 Coins in VEND, CHANGE, GAP or FAULT: not added; CoinReject pulses.
REQ-020 IDLE -> CREDIT when Credit becomes nonzero; CREDIT -> IDLE only through CHANGE or VEND.
REQ-021 Cancel in IDLE/CREDIT:
- Credit > 0: go to CHANGE.
- Credit = 0: ignore.
- Cancel has priority over Select in the same cycle.
- A coin arriving in the same cycle as Cancel is rejected.
REQ-022 Select in CREDIT with Credit >= PRICE: go to VEND and assert Dispense from the next cycle; a same-cycle coin is rejected.
REQ-023 Select with Credit < PRICE: ignore and stay in the current state; a same-cycle coin is still accepted under REQ-018.
REQ-024 VEND:
- Dispense stays high and the timeout counter increments each cycle.
- On VendDone: Credit -= PRICE and Dispense drops on the next cycle.
- After VendDone, go to CHANGE if the remainder > 0, else IDLE.
REQ-025 VEND timeout: if VendDone is not seen within VEND_TIMEOUT cycles of VEND entry:
- Go to FAULT.
- Dispense drops.
- Credit is retained (not deducted).
REQ-026 FAULT: Fault = 1; all inputs ignored except Reset; the only exit is Reset.
REQ-027 CHANGE/GAP refund loop:
- CHANGE pulses ReturnNickel for one cycle and decrements Credit by 1, then goes to GAP.
- GAP holds ReturnNickel low for one cycle.
- From GAP: go to CHANGE if Credit > 0, else IDLE.
- Result: one nickel per 2 cycles, Credit pulses in total.
REQ-028 VendDone outside VEND is ignored.
REQ-029 Credit never wraps; all arithmetic is 5-bit internally, saturation is handled by reject, and subtraction occurs only when Credit >= subtrahend.

Reset
REQ-030 When Reset = 0 at a rising edge, the next-cycle values are:
- State = IDLE.
- Credit = 0.
- Dispense, ReturnNickel, CoinReject and Fault = 0.
- Timeout counter = 0.
REQ-031 Reset mid-VEND or mid-CHANGE aborts immediately; remaining credit is discarded and no further ReturnNickel pulses occur.
REQ-032 After reset release, inputs are honoured from the first cycle.

Structure
REQ-033 Package vend_pkg holds the state codes, the coin values (NICKEL_VAL=1, DIME_VAL=2) and the Credit width constant.
REQ-034 Sub-module vend_credit holds the credit register, the add/saturate-reject logic and the decrement logic.
REQ-035 vend_ctrl holds the FSM and the timeout counter.

Verification
REQ-036 Nickel, Dime, Select -> Credit 1 then 3, Select ignored (3 < 4); then Nickel, Select -> Dispense high next cycle; VendDone -> Credit 0, IDLE, no ReturnNickel.
REQ-037 Dime x3, Select, VendDone after 5 cycles -> Credit 2, then exactly 2 ReturnNickel pulses 2 cycles apart, then IDLE.
REQ-038 Credit 14, Dime -> CoinReject pulse, Credit stays 14; Nickel -> Credit 15; Nickel+Dime together at 13 -> rejected, Credit 13.
REQ-039 Credit 6, Select, no VendDone for 255 cycles -> FAULT, Fault = 1, Credit 6, Dispense 0; Reset = 0 -> all outputs 0, State 000.
REQ-040 Credit 5, Select and Cancel in the same cycle -> CHANGE, 5 ReturnNickel pulses, no Dispense.
REQ-041 Credit 4, Cancel, Reset = 0 after the 2nd ReturnNickel -> no 3rd pulse, Credit 0, IDLE.
